// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: run-time modes and bounce direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Reusable prescaler: counts 0..DIV_MAX while enabled and strobes o_tick_pre on the wrap cycle.
module tick_gen #(
  parameter int unsigned DIV_MAX = 33554431
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_pre
);

  localparam int unsigned CW = $clog2(DIV_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_MAX);

  logic [CW-1:0] cnt_q;

  // Clear beats the wrap so a restart never emits a stray strobe.
  assign o_tick_pre = i_en && !i_clr && (cnt_q == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= o_tick_pre ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick drives COUNT/WALK/BOUNCE/BLINK patterns.
// Optional brightness PWM gating is enabled by defining LED_PWM_EN.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS         = 3,
  parameter int unsigned DIV_MAX        = 33554431,
  parameter bit          LED_ACTIVE_LOW = 1'b0,
  parameter int unsigned PWM_W          = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]  i_duty,
`endif
  output logic [N_LEDS-1:0] o_leds,
  output logic              o_tick
);

  if (N_LEDS < 1 || DIV_MAX < 1 || PWM_W < 1) begin : g_param_check
    $error("led_pattern_gen: N_LEDS, DIV_MAX and PWM_W must all be >= 1");
  end

  localparam logic [N_LEDS-1:0] PAT_ONE = N_LEDS'(1);

  mode_e             mode_q, mode_d;
  dir_e              dir_q, dir_d;
  logic [N_LEDS-1:0] pat_q, pat_d;
  logic              tick_q, tick_d;
  logic              mode_chg;
  logic              step;
  logic [N_LEDS-1:0] led_raw;

  function automatic logic [N_LEDS-1:0] init_pat(mode_e m);
    return (m == MODE_WALK || m == MODE_BOUNCE) ? PAT_ONE : '0;
  endfunction

  assign mode_chg = (mode_q != mode_e'(i_mode));

  tick_gen #(
    .DIV_MAX (DIV_MAX)
  ) u_tick_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_clr      (mode_chg),
    .o_tick_pre (step)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q <= MODE_COUNT;
      dir_q  <= DIR_LEFT;
      pat_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    tick_d = 1'b0;
    if (mode_chg) begin
      mode_d = mode_e'(i_mode);
      pat_d  = init_pat(mode_e'(i_mode));
      dir_d  = DIR_LEFT;
    end else if (step) begin
      tick_d = 1'b1;
      unique case (mode_q)
        MODE_COUNT: pat_d = pat_q + PAT_ONE;
        // For a single LED both shift terms collapse and the bit simply holds.
        MODE_WALK:  pat_d = (pat_q << 1) | (pat_q >> (N_LEDS - 1));
        MODE_BOUNCE: begin
          if (N_LEDS == 1) begin
            pat_d = pat_q;
          end else if (dir_q == DIR_LEFT) begin
            pat_d = pat_q << 1;
            if (pat_d[N_LEDS-1]) dir_d = DIR_RIGHT;
          end else begin
            pat_d = pat_q >> 1;
            if (pat_d[0]) dir_d = DIR_LEFT;
          end
        end
        MODE_BLINK: pat_d = ~pat_q;
        default:    pat_d = pat_q;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
    end
  end

  assign led_raw = pat_q & {N_LEDS{pwm_q < i_duty}};
`else
  assign led_raw = pat_q;
`endif

  assign o_leds = LED_ACTIVE_LOW ? ~led_raw : led_raw;
  assign o_tick = tick_q;

endmodule
